// File: rtl/scroll_char_plane_pkg.sv
// Shared encodings and defaults for the scrolling character plane.
package scroll_char_plane_pkg;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_SCROLL = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b10;

    localparam int BLANK_CHAR_DEF = 129;
    localparam int ERASE_CODE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL_ALL,
        ST_FILL_ROW
    } state_t;

endpackage

// File: rtl/scroll_char_plane_if.sv
// Writer/command/read bus between the terminal logic and the character plane.
interface scroll_char_plane_if #(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 6,
    parameter int CHAR_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [CHAR_W-1:0] wr_data;
    logic              wr_err;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic              cmd_ready;
    logic              busy;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [CHAR_W-1:0] rd_data;
    logic [ROW_W-1:0]  top_row;

    modport master (
        output wr_valid, wr_row, wr_col, wr_data, cmd_valid, cmd_op, rd_row, rd_col,
        input  wr_ready, wr_err, cmd_ready, busy, rd_data, top_row
    );

    modport slave (
        input  wr_valid, wr_row, wr_col, wr_data, cmd_valid, cmd_op, rd_row, rd_col,
        output wr_ready, wr_err, cmd_ready, busy, rd_data, top_row
    );
endinterface

// File: rtl/scroll_char_plane_ram.sv
// Simple dual-port character store: one write, one registered write-first read.
module scroll_char_plane_ram #(
    parameter int              DEPTH = 600,
    parameter int              AW    = 10,
    parameter int              DW    = 8,
    parameter logic [DW-1:0]   INIT  = '0
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH] = '{default: INIT};

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/scroll_char_plane.sv
// ROWS x COLS character plane with row-ring scroll offset, blanking fills and
// a write/command handshake; logical rows map to physical rows via top_row.
module scroll_char_plane
    import scroll_char_plane_pkg::*;
#(
    parameter int                ROWS       = 15,
    parameter int                COLS       = 40,
    parameter int                CHAR_W     = 8,
    parameter int                ROW_W      = 4,
    parameter int                COL_W      = 6,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = CHAR_W'(BLANK_CHAR_DEF),
    parameter logic [CHAR_W-1:0] ERASE_CODE = CHAR_W'(ERASE_CODE_DEF)
) (
    input  logic                clock,
    input  logic                reset,
    scroll_char_plane_if.slave  bus
);
    localparam int               DEPTH    = ROWS * COLS;
    localparam int               AW       = $clog2(DEPTH);
    localparam logic [ROW_W:0]   ROWS_X   = (ROW_W+1)'(ROWS);
    localparam logic [COL_W:0]   COLS_X   = (COL_W+1)'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  top_q, top_d;
    logic [ROW_W-1:0]  frow_q, frow_d;
    logic [COL_W-1:0]  fcol_q, fcol_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_blank_q;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [CHAR_W-1:0] ram_wdata, ram_rdata;
    logic              wr_in_range, rd_in_range;

    // Ring mapping by compare/subtract: both operands are < ROWS, so one subtract suffices.
    function automatic logic [ROW_W-1:0] map_row(input logic [ROW_W-1:0] row,
                                                 input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= ROWS_X) sum = sum - ROWS_X;
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                input logic [COL_W-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    assign wr_in_range = ({1'b0, bus.wr_row} < ROWS_X) && ({1'b0, bus.wr_col} < COLS_X);
    assign rd_in_range = ({1'b0, bus.rd_row} < ROWS_X) && ({1'b0, bus.rd_col} < COLS_X);
    assign ram_raddr   = rd_in_range ? cell_addr(map_row(bus.rd_row, top_q), bus.rd_col) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_FILL_ALL;
            top_q      <= '0;
            frow_q     <= '0;
            fcol_q     <= '0;
            wr_err_q   <= 1'b0;
            rd_blank_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            top_q      <= top_d;
            frow_q     <= frow_d;
            fcol_q     <= fcol_d;
            wr_err_q   <= wr_err_d;
            rd_blank_q <= !rd_in_range;
        end
    end

    always_comb begin
        state_d   = state_q;
        top_d     = top_q;
        frow_d    = frow_q;
        fcol_d    = fcol_q;
        wr_err_d  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = cell_addr(frow_q, fcol_q);
        ram_wdata = BLANK_CHAR;
        case (state_q)
            ST_FILL_ALL, ST_FILL_ROW: begin
                ram_we = 1'b1;
                fcol_d = fcol_q + 1'b1;
                if (fcol_q == LAST_COL) begin
                    fcol_d = '0;
                    if (state_q == ST_FILL_ROW || frow_q == LAST_ROW) state_d = ST_IDLE;
                    else frow_d = frow_q + 1'b1;
                end
            end
            default: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == CMD_SCROLL) begin
                        // Old top physical row becomes logical ROWS-1 and is blanked.
                        top_d   = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
                        frow_d  = top_q;
                        fcol_d  = '0;
                        state_d = ST_FILL_ROW;
                    end else if (bus.cmd_op == CMD_CLEAR) begin
                        top_d   = '0;
                        frow_d  = '0;
                        fcol_d  = '0;
                        state_d = ST_FILL_ALL;
                    end
                end else if (bus.wr_valid) begin
                    if (wr_in_range) begin
                        ram_we    = 1'b1;
                        ram_waddr = cell_addr(map_row(bus.wr_row, top_q), bus.wr_col);
                        ram_wdata = (bus.wr_data == ERASE_CODE) ? BLANK_CHAR : bus.wr_data;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
        endcase
        if (reset) ram_we = 1'b0;
    end

    scroll_char_plane_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (CHAR_W),
        .INIT  (BLANK_CHAR)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.wr_ready  = (state_q == ST_IDLE) && !bus.cmd_valid;
    assign bus.wr_err    = wr_err_q;
    assign bus.top_row   = top_q;
    assign bus.rd_data   = rd_blank_q ? BLANK_CHAR : ram_rdata;
endmodule
